// File: rtl/com_to_between_pkg.sv
// Shared encodings and constants for the UART-to-parallel return path.
// The CRC helper is used only when CRC8_EN is defined.
package com_to_between_pkg;
  localparam int         DATA_BITS = 8;
  localparam logic       UART_IDLE = 1'b1;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE     = 2'd0,
    T_LOAD     = 2'd1,
    T_WAIT_ACK = 2'd2,
    T_WAIT_REL = 2'd3
  } tx_state_e;

  // MSB-first CRC-8, one whole byte per call.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    c = crc_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/com_to_between_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit sampling.
// Emits a byte with a one-cycle valid strobe or a one-cycle framing-error strobe.
module uart_rx_byte
  import com_to_between_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o
);
  localparam int            TW      = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic [1:0]    rx_s_q;
  logic          rx_sync;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  assign rx_sync = rx_s_q[1];
  assign data_o  = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_q  <= {2{UART_IDLE}};
      state_q <= R_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_s_q  <= {rx_s_q[0], rx_i};
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_o = 1'b0;
    ferr_o  = 1'b0;
    case (state_q)
      R_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (rx_sync != UART_IDLE) state_d = R_START;
      end
      R_START: if (tick_q == HALF_M1) begin
        tick_d  = '0;
        // Line back high at mid start bit: treat as a glitch.
        state_d = (rx_sync == UART_IDLE) ? R_IDLE : R_DATA;
      end
      R_DATA: if (tick_q == FULL_M1) begin
        tick_d  = '0;
        shift_d = {rx_sync, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'(DATA_BITS - 1)) state_d = R_STOP;
      end
      R_STOP: if (tick_q == FULL_M1) begin
        tick_d  = '0;
        valid_o = rx_sync;
        ferr_o  = ~rx_sync;
        state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end
endmodule

// File: rtl/com_to_between.sv
// UART rx -> FIFO -> four-phase parallel handshake to the neighbour board.
// Define CRC8_EN to accumulate a CRC-8 over every delivered byte.
module com_to_between
  import com_to_between_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 16,
  parameter int PTR_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [7:0]       t_data,
  output logic             t_sent,
  input  logic             t_recv,
  output logic [PTR_W:0]   count,
  output logic             frame_err,
  output logic             overflow,
  output logic [7:0]       crc
);
  logic [7:0]       rx_byte;
  logic             rx_valid, rx_ferr;
  logic [1:0]       recv_s_q;
  logic             recv_sync;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [7:0]       t_data_q;
  logic             t_sent_q, frame_err_q, overflow_q;
  tx_state_e        tx_q, tx_d;
  logic             full, pop, push_ok;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk    (clk),
    .rst_n  (reset),
    .rx_i   (rx),
    .data_o (rx_byte),
    .valid_o(rx_valid),
    .ferr_o (rx_ferr)
  );

  assign recv_sync = recv_s_q[1];
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign pop       = (tx_q == T_IDLE) && (count_q != '0);
  // A simultaneous pop frees the slot the incoming byte needs.
  assign push_ok   = rx_valid && (!full || pop);

  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      T_IDLE:     if (count_q != '0) tx_d = T_LOAD;
      T_LOAD:     tx_d = T_WAIT_ACK;
      T_WAIT_ACK: if (recv_sync) tx_d = T_WAIT_REL;
      T_WAIT_REL: if (!recv_sync) tx_d = T_IDLE;
      default:    tx_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_s_q    <= '0;
      tx_q        <= T_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      t_data_q    <= '0;
      t_sent_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      recv_s_q <= {recv_s_q[0], t_recv};
      tx_q     <= tx_d;
      t_sent_q <= (tx_d == T_WAIT_ACK);
      count_q  <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      // Head byte is captured on the pop edge so it is stable during T_LOAD.
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        t_data_q <= mem_q[rd_ptr_q];
      end
      if (rx_ferr) frame_err_q <= 1'b1;
      if (rx_valid && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign t_data    = t_data_q;
  assign t_sent    = t_sent_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

`ifdef CRC8_EN
  logic [7:0] crc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_q <= '0;
    else if (tx_q == T_WAIT_ACK && recv_sync) crc_q <= crc8_next(crc_q, t_data_q);
  end
  assign crc = crc_q;
`else
  assign crc = 8'h00;
`endif
endmodule

// File: tb/tb_com_to_between.sv
// Directed bench for com_to_between at 16 clk/bit, 16-entry FIFO.
module tb_com_to_between;
  logic       clk, reset, rx, t_sent, t_recv, frame_err, overflow;
  logic [7:0] t_data, crc;
  logic [4:0] count;
  int         cyc = 0;
  int         n_chk = 0, n_pass = 0;

  com_to_between #(.CLKS_PER_BIT(16), .DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .t_data(t_data), .t_sent(t_sent),
    .t_recv(t_recv), .count(count), .frame_err(frame_err), .overflow(overflow), .crc(crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; step(16);
    for (int i = 0; i < 8; i++) begin rx = b[i]; step(16); end
    rx = stop; step(16);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0; step(3); reset = 1'b1; step(2);
  endtask

  task automatic deliver(input logic [7:0] exp);
    int w;
    w = 0;
    while (!t_sent && w < 400) begin step(1); w++; end
    n_chk++;
    if (!t_sent) $display("FAIL deliver_timeout: t_sent=%b want 1 (byte %h)", t_sent, exp);
    else if (t_data !== exp) $display("FAIL deliver_data: t_data=%h want %h", t_data, exp);
    else n_pass++;
    t_recv = 1'b1;
    w = 0;
    while (t_sent && w < 20) begin step(1); w++; end
    t_recv = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rx = 1'b1; t_recv = 1'b0; reset = 1'b0;
    step(3);
    n_chk++; if (t_data !== 8'h00) $display("FAIL rst_t_data: got %h want 00", t_data); else n_pass++;
    n_chk++; if (t_sent !== 1'b0) $display("FAIL rst_t_sent: got %b want 0", t_sent); else n_pass++;
    n_chk++; if (count !== 5'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (frame_err !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_flags: got fe=%b ov=%b want 0 0", frame_err, overflow); else n_pass++;
    n_chk++; if (crc !== 8'h00) $display("FAIL rst_crc: got %h want 00", crc); else n_pass++;
    reset = 1'b1; step(2);
  endtask

  task automatic test_basic();
    int c0, c_cnt, c_snt;
    logic [4:0] cnt_seen;
    logic [7:0] dat_seen;
    c0 = cyc; c_cnt = -1; c_snt = -1; cnt_seen = '0; dat_seen = '0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400 && c_snt < 0; i++) begin
          step(1);
          if (c_cnt < 0 && count != 0) begin c_cnt = cyc; cnt_seen = count; end
          if (t_sent) begin c_snt = cyc; dat_seen = t_data; end
        end
      end
    join
    n_chk++; if (c_cnt != c0 + 155 || cnt_seen !== 5'd1)
      $display("FAIL basic_count_lat: count=%0d at +%0d want 1 at +155", cnt_seen, c_cnt - c0); else n_pass++;
    n_chk++; if (c_snt < 0 || c_snt != c_cnt + 2)
      $display("FAIL basic_sent_lat: t_sent at +%0d want +%0d", c_snt - c0, c_cnt + 2 - c0); else n_pass++;
    n_chk++; if (dat_seen !== 8'hA5) $display("FAIL basic_data: got %h want a5", dat_seen); else n_pass++;
    step(5 - (cyc - c_snt));
    t_recv = 1'b1;
    step(2);
    n_chk++; if (t_sent !== 1'b1) $display("FAIL basic_sent_hold: got %b want 1", t_sent); else n_pass++;
    step(1);
    n_chk++; if (t_sent !== 1'b0) $display("FAIL basic_sent_fall: got %b want 0", t_sent); else n_pass++;
    t_recv = 1'b0;
    step(5);
    n_chk++; if (count !== 5'd0) $display("FAIL basic_count_end: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_glitch();
    rx = 1'b0; step(4); rx = 1'b1;
    step(60);
    n_chk++; if (count !== 5'd0 || t_sent !== 1'b0)
      $display("FAIL glitch_push: count=%0d t_sent=%b want 0 0", count, t_sent); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL glitch_ferr: got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    step(40);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", frame_err); else n_pass++;
    n_chk++; if (count !== 5'd0 || t_sent !== 1'b0)
      $display("FAIL ferr_nopush: count=%0d t_sent=%b want 0 0", count, t_sent); else n_pass++;
  endtask

  task automatic test_overflow();
    logic seen;
    t_recv = 1'b0;
    for (int b = 0; b < 18; b++) send_frame(8'(b), 1'b1);
    step(20);
    n_chk++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    n_chk++; if (t_data !== 8'h00 || t_sent !== 1'b1)
      $display("FAIL ovf_head: t_data=%h t_sent=%b want 00 1", t_data, t_sent); else n_pass++;
    n_chk++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky: got %b want 1", frame_err); else n_pass++;
    for (int b = 0; b < 17; b++) deliver(8'(b));
    n_chk++; if (count !== 5'd0) $display("FAIL ovf_drain: got %0d want 0", count); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin step(1); if (t_sent) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) $display("FAIL ovf_extra_byte: t_sent seen=%b want 0", seen); else n_pass++;
  endtask

  task automatic test_crc();
    logic [7:0] msg [9];
    logic [7:0] exp_crc;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
`ifdef CRC8_EN
    exp_crc = 8'hF4;
`else
    exp_crc = 8'h00;
`endif
    do_reset();
    n_chk++; if (frame_err !== 1'b0 || overflow !== 1'b0)
      $display("FAIL flags_clear: fe=%b ov=%b want 0 0", frame_err, overflow); else n_pass++;
    for (int i = 0; i < 9; i++) begin send_frame(msg[i], 1'b1); deliver(msg[i]); end
    n_chk++; if (crc !== exp_crc) $display("FAIL crc_check: got %h want %h", crc, exp_crc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [7:0] bytes [4];
    bytes[0] = 8'h55; bytes[1] = 8'h66; bytes[2] = 8'h77; bytes[3] = 8'h88;
    t_recv = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
    step(20);
    n_chk++; if (count !== 5'd3 || t_sent !== 1'b1)
      $display("FAIL mid_setup: count=%0d t_sent=%b want 3 1", count, t_sent); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (t_sent !== 1'b0) $display("FAIL mid_async_sent: got %b want 0", t_sent); else n_pass++;
    n_chk++; if (count !== 5'd0 || t_data !== 8'h00)
      $display("FAIL mid_async_clear: count=%0d t_data=%h want 0 00", count, t_data); else n_pass++;
    @(posedge clk); #1;
    step(3);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin step(1); if (t_sent || count != 0) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) $display("FAIL mid_stale: stale activity=%b want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_crc();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
